cabac_binari_sig_flag_ctrl: RTL and testbench

//  Sequences sig_coeff_flag coding for one 4x4 coefficient group (CG) in reverse scan order.

---
 rtl/cabac_binari_sig_flag_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cabac_binari_sig_flag_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_binari_sig_flag_ctrl.sv
// sig_coeff_flag sequencer for one 4x4 CG, reverse scan, valid/ready bin output.
// Optional bin statistics counter enabled by defining CABAC_SIG_STAT_EN.
module cabac_binari_sig_flag_ctrl #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        cg_x_i,
    input  logic [2:0]        cg_y_i,
    input  logic [1:0]        scan_idx_i,
    input  logic [3:0]        last_pos_i,
    input  logic              is_last_cg_i,
    input  logic              csbf_i,
    input  logic [15:0]       sig_map_i,
    output logic [4:0]        pos_x_o,
    output logic [4:0]        pos_y_o,
    input  logic [7:0]        ctx_addr_i,
    output logic              bin_valid_o,
    output logic              bin_val_o,
    output logic [7:0]        ctx_addr_o,
    input  logic              bin_ready_i,
    output logic              busy_o,
    output logic              done_o
`ifdef CABAC_SIG_STAT_EN
    ,
    output logic [STAT_W-1:0] sig_bin_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic [2:0]  cgx_q, cgy_q;
    logic [1:0]  scan_q;
    logic        last_q;
    logic [15:0] map_q;

    logic [1:0]  sub_x, sub_y;
    logic        run, hs, bin_val, infer, cfg_ld;

    assign run    = (state_q == S_RUN);
    assign hs     = run & bin_ready_i;
    assign cfg_ld = (state_q == S_IDLE) & start_i;

    always_comb begin
        sub_x = cnt_q[1:0];
        sub_y = cnt_q[3:2];
        unique case (scan_q)
            2'd1: begin
                sub_x = cnt_q[1:0];
                sub_y = cnt_q[3:2];
            end
            2'd2: begin
                sub_x = cnt_q[3:2];
                sub_y = cnt_q[1:0];
            end
            default: begin
                // up-right diagonal scan, entries are {x, y}
                unique case (cnt_q)
                    4'd0:    {sub_x, sub_y} = {2'd0, 2'd0};
                    4'd1:    {sub_x, sub_y} = {2'd0, 2'd1};
                    4'd2:    {sub_x, sub_y} = {2'd1, 2'd0};
                    4'd3:    {sub_x, sub_y} = {2'd0, 2'd2};
                    4'd4:    {sub_x, sub_y} = {2'd1, 2'd1};
                    4'd5:    {sub_x, sub_y} = {2'd2, 2'd0};
                    4'd6:    {sub_x, sub_y} = {2'd0, 2'd3};
                    4'd7:    {sub_x, sub_y} = {2'd1, 2'd2};
                    4'd8:    {sub_x, sub_y} = {2'd2, 2'd1};
                    4'd9:    {sub_x, sub_y} = {2'd3, 2'd0};
                    4'd10:   {sub_x, sub_y} = {2'd1, 2'd3};
                    4'd11:   {sub_x, sub_y} = {2'd2, 2'd2};
                    4'd12:   {sub_x, sub_y} = {2'd3, 2'd1};
                    4'd13:   {sub_x, sub_y} = {2'd2, 2'd3};
                    4'd14:   {sub_x, sub_y} = {2'd3, 2'd2};
                    default: {sub_x, sub_y} = {2'd3, 2'd3};
                endcase
            end
        endcase
    end

    assign bin_val = map_q[{sub_y, sub_x}];
    // DC flag is implied when nothing else in a non-first, non-last CG was significant
    assign infer   = !last_q && ({cgx_q, cgy_q} != 6'd0) && !(seen_q || bin_val);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    seen_d = 1'b0;
                    cnt_d  = is_last_cg_i ? (last_pos_i - 4'd1) : 4'd15;
                    if (!csbf_i || (is_last_cg_i && (last_pos_i == 4'd0))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (hs) begin
                    seen_d = seen_q | bin_val;
                    if ((cnt_q == 4'd0) || ((cnt_q == 4'd1) && infer)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cgx_q  <= 3'd0;
            cgy_q  <= 3'd0;
            scan_q <= 2'd0;
            last_q <= 1'b0;
            map_q  <= 16'd0;
        end else if (cfg_ld) begin
            cgx_q  <= cg_x_i;
            cgy_q  <= cg_y_i;
            scan_q <= scan_idx_i;
            last_q <= is_last_cg_i;
            map_q  <= sig_map_i;
        end
    end

    assign pos_x_o     = run ? {cgx_q, sub_x} : 5'd0;
    assign pos_y_o     = run ? {cgy_q, sub_y} : 5'd0;
    assign bin_valid_o = run;
    assign bin_val_o   = run & bin_val;
    assign ctx_addr_o  = run ? ctx_addr_i : 8'd0;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

`ifdef CABAC_SIG_STAT_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (hs && (stat_q != {STAT_W{1'b1}})) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign sig_bin_cnt_o = stat_q;
`else
    logic [STAT_W-1:0] stat_unused;
    assign stat_unused = '0;
`endif

endmodule

// File: tb/tb_cabac_binari_sig_flag_ctrl.sv
// Bench for cabac_binari_sig_flag_ctrl: directed vector table, reset-abort
// sequence and randomized CGs against a scan-order reference model.
module tb_cabac_binari_sig_flag_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  cg_x_i = '0;
    logic [2:0]  cg_y_i = '0;
    logic [1:0]  scan_idx_i = '0;
    logic [3:0]  last_pos_i = '0;
    logic        is_last_cg_i = 1'b0;
    logic        csbf_i = 1'b0;
    logic [15:0] sig_map_i = '0;
    logic [4:0]  pos_x_o, pos_y_o;
    logic [7:0]  ctx_addr_i;
    logic        bin_valid_o, bin_val_o;
    logic [7:0]  ctx_addr_o;
    logic        bin_ready_i = 1'b0;
    logic        busy_o, done_o;
`ifdef CABAC_SIG_STAT_EN
    logic [15:0] sig_bin_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int stat_model = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] ctxf(input int x, input int y);
        int t;
        t = x * 7 + y * 13;
        return t[7:0];
    endfunction

    always_comb ctx_addr_i = ctxf(int'(pos_x_o), int'(pos_y_o));

    cabac_binari_sig_flag_ctrl #(.STAT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .cg_x_i       (cg_x_i),
        .cg_y_i       (cg_y_i),
        .scan_idx_i   (scan_idx_i),
        .last_pos_i   (last_pos_i),
        .is_last_cg_i (is_last_cg_i),
        .csbf_i       (csbf_i),
        .sig_map_i    (sig_map_i),
        .pos_x_o      (pos_x_o),
        .pos_y_o      (pos_y_o),
        .ctx_addr_i   (ctx_addr_i),
        .bin_valid_o  (bin_valid_o),
        .bin_val_o    (bin_val_o),
        .ctx_addr_o   (ctx_addr_o),
        .bin_ready_i  (bin_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef CABAC_SIG_STAT_EN
        ,
        .sig_bin_cnt_o(sig_bin_cnt_o)
`endif
    );

    typedef struct {
        int          scan;
        int          cgx;
        int          cgy;
        int          last;
        int          lastpos;
        int          csbf;
        logic [15:0] map;
    } cfg_t;

    typedef struct {
        cfg_t  c;
        int    mode;
        int    exp_n;
        int    px0;
        int    py0;
        string tag;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Scan position p -> (x, y); diagonal built by walking anti-diagonals upward-right
    task automatic scan_pos(input int sc, input int p, output int x, output int y);
        int k;
        x = 0;
        y = 0;
        if (sc == 1) begin
            x = p % 4;
            y = p / 4;
        end else if (sc == 2) begin
            x = p / 4;
            y = p % 4;
        end else begin
            k = 0;
            for (int d = 0; d < 7; d++) begin
                for (int xx = 0; xx < 4; xx++) begin
                    if (d - xx >= 0 && d - xx <= 3) begin
                        if (k == p) begin
                            x = xx;
                            y = d - xx;
                        end
                        k++;
                    end
                end
            end
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        scan_idx_i   = 2'(c.scan);
        cg_x_i       = 3'(c.cgx);
        cg_y_i       = 3'(c.cgy);
        is_last_cg_i = (c.last != 0);
        last_pos_i   = 4'(c.lastpos);
        csbf_i       = (c.csbf != 0);
        sig_map_i    = c.map;
    endtask

    task automatic scramble_cfg();
        scan_idx_i   = 2'($urandom);
        cg_x_i       = 3'($urandom);
        cg_y_i       = 3'($urandom);
        is_last_cg_i = 1'($urandom);
        last_pos_i   = 4'($urandom);
        csbf_i       = 1'($urandom);
        sig_map_i    = 16'($urandom);
    endtask

    task automatic check_stat(input string nm);
`ifdef CABAC_SIG_STAT_EN
        chk(nm, 32'(sig_bin_cnt_o), stat_model);
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low 3 cycles per bin
    task automatic run_cg(input cfg_t c, input int mode, input int exp_n,
                          input int px0, input int py0, input string tag);
        int q_v[$];
        int q_x[$];
        int q_y[$];
        int st, x, y, v, seen, idx, stall, fin;
        bit rdy;
        if (c.csbf != 0 && !(c.last != 0 && c.lastpos == 0)) begin
            st   = (c.last != 0) ? c.lastpos - 1 : 15;
            seen = 0;
            for (int p = st; p >= 0; p--) begin
                scan_pos(c.scan, p, x, y);
                v = int'(c.map[y * 4 + x]);
                q_v.push_back(v);
                q_x.push_back(c.cgx * 4 + x);
                q_y.push_back(c.cgy * 4 + y);
                seen |= v;
                if (p == 1 && c.last == 0 && (c.cgx != 0 || c.cgy != 0) && seen == 0) break;
            end
        end
        @(negedge clk);
        drive_cfg(c);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        scramble_cfg();
        idx   = 0;
        stall = 0;
        fin   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk({tag, " busy"}, 32'(busy_o), 1);
            if (idx == q_v.size()) begin
                chk({tag, " done"}, 32'(done_o), 1);
                chk({tag, " valid_at_done"}, 32'(bin_valid_o), 0);
                fin = 1;
                break;
            end
            chk({tag, " valid"}, 32'(bin_valid_o), 1);
            chk({tag, " done_early"}, 32'(done_o), 0);
            chk({tag, " bin_val"}, 32'(bin_val_o), q_v[idx]);
            chk({tag, " pos_x"}, 32'(pos_x_o), q_x[idx]);
            chk({tag, " pos_y"}, 32'(pos_y_o), q_y[idx]);
            chk({tag, " ctx"}, 32'(ctx_addr_o), 32'(ctxf(q_x[idx], q_y[idx])));
            if (cyc == 0 && px0 >= 0) begin
                chk({tag, " first_pos_x"}, 32'(pos_x_o), px0);
                chk({tag, " first_pos_y"}, 32'(pos_y_o), py0);
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom);
            else if (stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy   = 1'b1;
                stall = 0;
            end
            bin_ready_i = rdy;
            if (rdy) begin
                idx++;
                if (stat_model < 65535) stat_model++;
            end
            @(negedge clk);
            scramble_cfg();
        end
        bin_ready_i = 1'b0;
        chk({tag, " finished_in_budget"}, 32'(fin), 1);
        if (exp_n >= 0) chk({tag, " bin_count"}, 32'(idx), exp_n);
        @(negedge clk);
        chk({tag, " idle_busy"}, 32'(busy_o), 0);
        chk({tag, " idle_done"}, 32'(done_o), 0);
        chk({tag, " idle_valid"}, 32'(bin_valid_o), 0);
        check_stat({tag, " stat"});
    endtask

    vec_t vecs[8];
    cfg_t c2;
    cfg_t rc;

    initial begin
        vecs[0] = '{'{0, 0, 0, 1, 5, 1, 16'h0013}, 0, 5, 1, 1, "diag_last5"};
        vecs[1] = '{'{1, 1, 0, 0, 0, 1, 16'h0001}, 0, 15, 7, 3, "hor_infer"};
        vecs[2] = '{'{0, 2, 3, 0, 0, 0, 16'hFFFF}, 0, 0, -1, -1, "csbf0"};
        vecs[3] = '{'{2, 0, 0, 0, 0, 1, 16'h0000}, 0, 16, 3, 3, "ver_cg0"};
        vecs[4] = '{'{0, 0, 0, 1, 5, 1, 16'h0013}, 2, 5, 1, 1, "diag_stall"};
        vecs[5] = '{'{3, 1, 1, 1, 0, 1, 16'hFFFF}, 0, 0, -1, -1, "last_pos0"};
        vecs[6] = '{'{0, 2, 1, 0, 0, 1, 16'h0000}, 0, 15, 11, 7, "diag_infer"};
        vecs[7] = '{'{2, 1, 1, 0, 0, 1, 16'h8000}, 1, 16, 7, 7, "ver_noinfer"};

        #1;
        chk("reset busy", 32'(busy_o), 0);
        chk("reset done", 32'(done_o), 0);
        chk("reset valid", 32'(bin_valid_o), 0);
        chk("reset pos", 32'({pos_x_o, pos_y_o}), 0);
        chk("reset ctx", 32'(ctx_addr_o), 0);
        check_stat("reset stat");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_cg(vecs[i].c, vecs[i].mode, vecs[i].exp_n,
                   vecs[i].px0, vecs[i].py0, vecs[i].tag);

        // abort in the middle of the third bin of the horizontal inferred CG
        c2 = vecs[1].c;
        @(negedge clk);
        drive_cfg(c2);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        bin_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort third_valid", 32'(bin_valid_o), 1);
        chk("abort third_pos_x", 32'(pos_x_o), 5);
        chk("abort third_pos_y", 32'(pos_y_o), 3);
        rst_n = 1'b0;
        #1;
        chk("abort valid", 32'(bin_valid_o), 0);
        chk("abort busy", 32'(busy_o), 0);
        chk("abort done", 32'(done_o), 0);
        chk("abort pos", 32'({pos_x_o, pos_y_o}), 0);
        chk("abort bin_val", 32'(bin_val_o), 0);
        bin_ready_i = 1'b0;
        stat_model = 0;
        @(negedge clk);
        chk("abort no_done", 32'(done_o), 0);
        check_stat("abort stat_zero");
        rst_n = 1'b1;
        run_cg(c2, 1, 15, 7, 3, "rerun");

        for (int n = 0; n < 40; n++) begin
            rc.scan    = int'($urandom_range(0, 3));
            rc.cgx     = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 7));
            rc.cgy     = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 7));
            rc.last    = int'($urandom_range(0, 1));
            rc.lastpos = int'($urandom_range(0, 15));
            rc.csbf    = ($urandom_range(0, 4) != 0) ? 1 : 0;
            rc.map     = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rc.map &= 16'($urandom_range(0, 3));
            run_cg(rc, int'($urandom_range(0, 1)), -1, -1, -1, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
